// File: rtl/network_sel_ctrl_pkg.sv
// Shared types and constants for the NTT butterfly output network sequencer.
// Patterns pack {sel_a_0, sel_a_1, sel_a_2, sel_a_3}, two bits each.
package ntt_net_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] SEL_BF0_LO = 2'b00;
  localparam logic [1:0] SEL_BF0_UP = 2'b01;
  localparam logic [1:0] SEL_BF1_LO = 2'b10;
  localparam logic [1:0] SEL_BF1_UP = 2'b11;

  localparam logic [7:0] PAT_A = {
    SEL_BF0_UP, SEL_BF0_LO,
    SEL_BF1_UP, SEL_BF1_LO
  };
  localparam logic [7:0] PAT_B = {
    SEL_BF0_UP, SEL_BF1_UP,
    SEL_BF0_LO, SEL_BF1_LO
  };

  localparam int DRAIN_R2 = 7;
  localparam int DRAIN_R4 = 13;

endpackage

// File: rtl/network_sel_ctrl_if.sv
// Control/status bundle between the NTT sequencer and its driver.
// master drives start/mode/stall; slave is the sequencer.
interface network_sel_ctrl_if #(
  parameter int LOG_N = 8
);
  localparam int SW = $clog2(LOG_N);

  logic          start;
  logic          mode;
  logic          stall;
  logic          sel;
  logic          sen;
  logic [1:0]    sel_a_0;
  logic [1:0]    sel_a_1;
  logic [1:0]    sel_a_2;
  logic [1:0]    sel_a_3;
  logic [SW-1:0] stage;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, stall,
    input  sel, sen, stage, busy, done,
    input  sel_a_0, sel_a_1, sel_a_2, sel_a_3
  );

  modport slave (
    input  start, mode, stall,
    output sel, sen, stage, busy, done,
    output sel_a_0, sel_a_1, sel_a_2, sel_a_3
  );

endinterface

// File: rtl/network_sel_pattern.sv
// Maps (mode, stage, last-stage flag) to the four butterfly select codes.
// The last stage always uses pattern A regardless of mode.
module network_sel_pattern
  import ntt_net_pkg::*;
#(
  parameter int SW = 3
) (
  input  logic          mode,
  input  logic [SW-1:0] stage,
  input  logic          last,
  output logic [1:0]    sel_a_0,
  output logic [1:0]    sel_a_1,
  output logic [1:0]    sel_a_2,
  output logic [1:0]    sel_a_3
);

  logic [7:0] pat;

  always_comb begin
    pat = PAT_A;
    unique case (1'b1)
      last:                      pat = PAT_A;
      !last && mode:             pat = PAT_B;
      !last && !mode && stage[0]: pat = PAT_B;
      default:                   pat = PAT_A;
    endcase
  end

  assign sel_a_0 = pat[7:6];
  assign sel_a_1 = pat[5:4];
  assign sel_a_2 = pat[3:2];
  assign sel_a_3 = pat[1:0];

endmodule

// File: rtl/network_sel_ctrl.sv
// Sequencer for the mixed-radix NTT output network: walks stages and
// issue cycles, then drains the network's select delay before done.
module network_sel_ctrl
  import ntt_net_pkg::*;
#(
  parameter int LOG_N = 8
) (
  input logic clk,
  input logic rst,
  network_sel_ctrl_if.slave bus
);

  localparam int SW = $clog2(LOG_N);
  localparam int CW = LOG_N - 2;

  localparam logic [CW-1:0] CNT_LAST = '1;
  localparam logic [SW-1:0] LAST_R2 = SW'(LOG_N - 1);
  localparam logic [SW-1:0] LAST_R4 = SW'(LOG_N / 2 - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    dcnt;
  logic          mode_q;
  logic [SW-1:0] stage_q;
  logic          sel_q;
  logic          sen_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    sa0_q, sa1_q, sa2_q, sa3_q;

  logic          mode_nxt;
  logic [SW-1:0] s_last;
  logic [SW-1:0] stage_nxt;
  logic          adv;
  logic [3:0]    d_last;
  logic [1:0]    p0, p1, p2, p3;

  always_comb begin
    mode_nxt  = (state == IDLE) ? bus.mode : mode_q;
    s_last    = mode_nxt ? LAST_R4 : LAST_R2;
    adv       = mode_q | ~bus.stall;
    d_last    = mode_q ? 4'(DRAIN_R4 - 1)
                       : 4'(DRAIN_R2 - 1);
    stage_nxt = stage_q;
    if (state == IDLE)
      stage_nxt = '0;
    else if (state == RUN && adv &&
             cnt == CNT_LAST &&
             stage_q != s_last)
      stage_nxt = stage_q + 1'b1;
  end

  // Codes are looked up for the stage about to be issued, then registered.
  network_sel_pattern #(
    .SW(SW)
  ) u_pat (
    .mode    (mode_nxt),
    .stage   (stage_nxt),
    .last    (stage_nxt == s_last),
    .sel_a_0 (p0),
    .sel_a_1 (p1),
    .sel_a_2 (p2),
    .sel_a_3 (p3)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dcnt    <= '0;
      mode_q  <= 1'b0;
      stage_q <= '0;
      sel_q   <= 1'b0;
      sen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sa0_q   <= 2'b00;
      sa1_q   <= 2'b00;
      sa2_q   <= 2'b00;
      sa3_q   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            mode_q  <= bus.mode;
            sel_q   <= bus.mode;
            sen_q   <= ~bus.mode;
            busy_q  <= 1'b1;
            cnt     <= '0;
            dcnt    <= '0;
            stage_q <= stage_nxt;
            sa0_q   <= p0;
            sa1_q   <= p1;
            sa2_q   <= p2;
            sa3_q   <= p3;
          end
        end
        RUN: begin
          sen_q   <= ~mode_q & ~bus.stall;
          stage_q <= stage_nxt;
          sa0_q   <= p0;
          sa1_q   <= p1;
          sa2_q   <= p2;
          sa3_q   <= p3;
          if (adv) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (stage_q == s_last) begin
                state <= DRAIN;
                dcnt  <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          sen_q <= ~mode_q & ~bus.stall;
          if (adv) begin
            if (dcnt == d_last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              sen_q  <= 1'b0;
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sen     = sen_q;
  assign bus.stage   = stage_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sel_a_0 = sa0_q;
  assign bus.sel_a_1 = sa1_q;
  assign bus.sel_a_2 = sa2_q;
  assign bus.sel_a_3 = sa3_q;

endmodule

// File: doc/network_sel_ctrl.md
# network_sel_ctrl

Sequencing controller for the butterfly output network of the mixed-radix NTT datapath. On `start` it walks every stage and every issue cycle of one transform. It drives the network's per-output select codes `sel_a_*`, the delay-path choice `sel` and the gated-path enable `sen`. It then waits out the network's internal select delay (7 gated cycles in radix-2 mode, 13 free-running cycles in radix-4 mode) before pulsing `done`.

## Interface
- `LOG_N`, 8: log2 of transform size N. Must be even and ≥ 4.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transform. Sampled only in IDLE.
- `mode`  in  1  0 = radix-2 (gated 7-deep select path), 1 = radix-4 (free 13-deep path). Latched at start.
- `stall`  in  1  pause request. Honoured in mode 0 only.
- `sel`  out  1  delay-path choice to the network. Equals the latched mode.
- `sen`  out  1  clock enable for the gated select path.
- `sel_a_0`, `sel_a_1`, `sel_a_2`, `sel_a_3`  out  2 each  select codes. 00 = bf0 lower, 01 = bf0 upper, 10 = bf1 lower, 11 = bf1 upper.
- `stage`  out  $clog2(LOG_N)  current stage index.
- `busy`  out  1  high from RUN through DRAIN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the last issue cycle.
  - DRAIN → DONE when the drain count is reached.
  - DONE → IDLE unconditionally.
- Stages per transform:
  - S = LOG_N in mode 0.
  - S = LOG_N/2 in mode 1.
- Issue cycles per stage: N/4, counted by `cnt` of width LOG_N-2.
- Select patterns, listed as {sel_a_0, sel_a_1, sel_a_2, sel_a_3}:
  - Pattern A = {01,00,11,10}.
  - Pattern B = {01,11,00,10}.
- Pattern choice:
  - Mode 0: A on even stages, B on odd stages.
  - Mode 1: B on every stage.
  - Both modes: the final stage (S-1) always uses A.
- Stall handling:
  - Mode 0, `stall`=1 in RUN or DRAIN: `cnt`, `stage` and the drain counter freeze, and `sen`=0 on the following cycle.
  - Mode 1: `stall` is ignored, because the 13-deep path cannot be paused.
- `sen`:
  - Mode 0, RUN or DRAIN: `sen` = !stall, registered.
  - Otherwise: 0.
- Drain:
  - Mode 0: 7 cycles, advanced only on cycles with `sen`=1.
  - Mode 1: 13 cycles, free-running.
  - `sel` and the last `sel_a_*` values hold throughout DRAIN.
- `start` in RUN, DRAIN or DONE is ignored. Changes to `mode` after start are ignored.

## Timing
- All outputs are registered.
- Reset values (async, `rst`=0):
  - state IDLE.
  - `sel`, `sen`, `busy`, `done` = 0.
  - `sel_a_*` = 00.
  - `stage` = 0.
  - internal counters = 0.
- Cycle numbering: `start` is sampled at edge 0.
  - The first issue values are visible in cycle 1.
  - `busy` = 1 from cycle 1.
- Without stall, `done` is high in cycle S·N/4 + D + 1, where D = 7 (mode 0) or 13 (mode 1).
  - `busy` falls in the same cycle `done` rises.
  - The first cycle in which a new `start` is accepted is the cycle after `done`.
- `stage` increments on the edge after the cycle in which `cnt` = N/4−1 is issued. `cnt` wraps to 0.
- Reset asserted mid-transform aborts immediately with no `done` pulse.

## Structure
- Shared package `ntt_net_pkg` holds:
  - the state enum;
  - pattern constants PAT_A and PAT_B;
  - select codes SEL_BF0_LO, SEL_BF0_UP, SEL_BF1_LO, SEL_BF1_UP;
  - drain depths DRAIN_R2 = 7 and DRAIN_R4 = 13.
- Sub-module `network_sel_pattern`: combinational map from (mode, stage, last-stage flag) to the four codes.
- Counters and FSM stay in the top module.

## Test plan
- Reset check: LOG_N=4, hold `rst`=0, then release. Required: all outputs 0 and `sel_a_*` = 00.
- Mode 0, no stall, `start` at cycle 0. Required:
  - 16 issue cycles, stages 0..3.
  - Patterns A,B,A,A, each held for 4 cycles.
  - `sen`=1 in cycles 1–23.
  - `done` in cycle 24 only.
- Mode 1, no stall. Required:
  - 8 issue cycles.
  - `sel`=1 throughout; `sen`=0 throughout.
  - Pattern B for stage 0, then A for stage 1.
  - `done` in cycle 22.
- Mode 0, `stall` high for 3 cycles mid-stage 1 and for 2 cycles during DRAIN. Required:
  - `cnt` and `sel_a_*` freeze.
  - `sen`=0 for exactly those cycles.
  - `done` moves to cycle 29.
- Mode 1 with `stall` toggling. Required: timing is identical to the no-stall run and `done` is in cycle 22.
- `start` pulsed in cycles 5 and 22 of a mode 0 run, and `rst` asserted in cycle 10 of a second run. Required:
  - The repeated starts are ignored; the first run's `done` is still in cycle 24.
  - The second run aborts to reset values with no `done` pulse.
